clk_div_multi: RTL

Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the fixed-ratio divider. Each of NUM_CH channels produces a one-cycle tick strobe and a square-wave level at a divisor loaded over a valid/ready config port. New divisors take effect glitch-free at the channel's period boundary. The block sits beside the UART and timers and supplies baud/sample ticks and slow indicator clocks from the single system clock.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_channel.sv | 59 +++++
 rtl/clk_div_multi.sv | 72 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers
// for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel-index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with
// active/pending divisor swapped at the period boundary.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 27,
  parameter int DEFAULT_DIV = 100_000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  localparam logic [DIV_W-1:0] DEF_DIV =
    (DEFAULT_DIV < MIN_DIV) ? DIV_W'(MIN_DIV)
                            : DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] cnt_nx;
  logic             idle;
  logic             wrap;

  assign idle   = restart || !en;
  assign wrap   = (cnt == act_div - DIV_W'(1));
  assign cnt_nx = (idle || wrap) ? '0 : cnt + DIV_W'(1);

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt      <= '0;
      act_div  <= DEF_DIV;
      pend_div <= DEF_DIV;
      pend     <= 1'b0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      tick    <= !idle && wrap;
      clk_out <= (cnt_nx >= (act_div >> 1));
      if ((idle || wrap) && pend) begin
        act_div <= pend_div;
        pend    <= 1'b0;
      end
      // A load on a boundary edge stays pending for the next one.
      if (load) begin
        pend_div <= load_div;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH runtime-programmable clock dividers
// sharing one valid/ready config port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  CLK_HZ      = 100_000_000,
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = 27,
  parameter int  DEFAULT_DIV = 100_000,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend_out
);

  if (NUM_CH < 1 || NUM_CH > 16 || CLK_HZ < 1) begin : g_bad_cfg
    $error("clk_div_multi: unsupported parameters");
  end

  logic [DIV_W-1:0]  div_c;
  logic [NUM_CH-1:0] load;
  logic              pend_sel;
  logic              acc;

  assign div_c = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV)
                                             : cfg_div;

  // Out-of-range channels read as never pending: accepted, dropped.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) pend_sel = pend_out[i];
    end
  end

  assign cfg_ready = !rst && !pend_sel;
  assign acc       = cfg_valid && cfg_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) load[i] = acc;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clkin    (clkin),
      .rst      (rst),
      .en       (ch_en[g]),
      .restart  (sync_restart),
      .load     (load[g]),
      .load_div (div_c),
      .tick     (tick_out[g]),
      .clk_out  (clk_out[g]),
      .pend     (pend_out[g])
    );
  end

endmodule
